fifo_ctrl_thresh: RTL and testbench

//   Parametrised pointer/flag controller for a single-clock FIFO; drives the addresses of an external dual-port RAM.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_ptr_wrap.sv | 43 ++++
 rtl/fifo_ctrl_thresh.sv | 164 ++++++++++++++++
 tb/tb_fifo_ctrl_thresh.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared types and helpers for the threshold FIFO controller.
//   - fifo_op_t : per-cycle operation, encoded as {wr_en, rd_en}
//   - params_ok : legality check for the controller parameters, used at
//                 elaboration time by the controller and pointer modules
// ---------------------------------------------------------------------------
package fifo_pkg;

   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_RD   = 2'b01,
      OP_WR   = 2'b10,
      OP_RDWR = 2'b11
   } fifo_op_t;

   // DEPTH must fit in the pointer range, AF_LEVEL in 1..DEPTH and
   // AE_LEVEL in 0..DEPTH-1.
   function automatic bit params_ok(input int aw, input int depth,
                                    input int af, input int ae);
      return (aw >= 1) && (aw <= 30) &&
             (depth >= 2) && (depth <= (1 << aw)) &&
             (af >= 1) && (af <= depth) &&
             (ae >= 0) && (ae <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// ---------------------------------------------------------------------------
// fifo_ptr_wrap
//   Registered FIFO pointer with increment enable and synchronous clear.
//   Wraps from DEPTH-1 to 0 by explicit compare, so DEPTH need not be a
//   power of two.
// Ports
//   i_clk  in   1   clock, rising edge
//   i_rst  in   1   asynchronous active-high reset (pointer -> 0)
//   i_clr  in   1   synchronous clear (pointer -> 0), overrides i_inc
//   i_inc  in   1   advance pointer by one
//   o_ptr  out  AW  current pointer value
// ---------------------------------------------------------------------------
module fifo_ptr_wrap
   import fifo_pkg::*;
#(
   parameter int AW    = 4,
   parameter int DEPTH = 16
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [AW-1:0] o_ptr
);

   if (!params_ok(AW, DEPTH, 1, 0)) begin : g_bad_params
      $error("fifo_ptr_wrap: DEPTH must be in 2..2**AW");
   end

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] ONE  = AW'(1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_ptr <= '0;
      end else if (i_clr) begin
         o_ptr <= '0;
      end else if (i_inc) begin
         o_ptr <= (o_ptr == LAST) ? '0 : o_ptr + ONE;
      end
   end

endmodule

// File: rtl/fifo_ctrl_thresh.sv
// ---------------------------------------------------------------------------
// fifo_ctrl_thresh
//   Pointer/flag controller for a single-clock FIFO built around an external
//   dual-port RAM. Supports arbitrary DEPTH, an occupancy count,
//   almost-full/almost-empty thresholds, synchronous flush and sticky
//   overflow/underflow errors.
// Ports
//   i_clk        in   1     clock, rising edge
//   i_rst        in   1     asynchronous active-high reset
//   i_wr         in   1     push request
//   i_rd         in   1     pop request
//   i_clr        in   1     synchronous flush (highest priority after reset)
//   o_wr_en      out  1     push accepted this cycle (combinational)
//   o_rd_en      out  1     pop accepted this cycle (combinational)
//   o_waddr      out  AW    RAM write address
//   o_raddr      out  AW    RAM read address
//   o_count      out  AW+1  occupancy 0..DEPTH
//   o_full       out  1     count == DEPTH
//   o_empty      out  1     count == 0
//   o_afull      out  1     count >= AF_LEVEL
//   o_aempty     out  1     count <= AE_LEVEL
//   o_overflow   out  1     sticky: push attempted while full
//   o_underflow  out  1     sticky: pop attempted while empty
//
// Handshake: i_wr/i_rd act as valid, and ~o_full/~o_empty act as ready.
// A request is accepted (o_wr_en/o_rd_en high) in the same cycle it is
// presented if the FIFO can take it and i_clr is low; a rejected request
// is dropped, not held, and only leaves its mark in the sticky error flag.
// ---------------------------------------------------------------------------
module fifo_ctrl_thresh
   import fifo_pkg::*;
#(
   parameter int AW       = 4,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 12,
   parameter int AE_LEVEL = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr,
   input  logic          i_rd,
   input  logic          i_clr,
   output logic          o_wr_en,
   output logic          o_rd_en,
   output logic [AW-1:0] o_waddr,
   output logic [AW-1:0] o_raddr,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_afull,
   output logic          o_aempty,
   output logic          o_overflow,
   output logic          o_underflow
);

   if (!params_ok(AW, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
      $error("fifo_ctrl_thresh: illegal DEPTH/AF_LEVEL/AE_LEVEL for AW");
   end

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
   localparam logic [AW:0] ONE_C   = (AW+1)'(1);

   fifo_op_t    op;
   logic [AW:0] count_nxt;
   logic        full_nxt;
   logic        empty_nxt;
   logic        afull_nxt;
   logic        aempty_nxt;
   logic        overflow_nxt;
   logic        underflow_nxt;

   // Acceptance uses the registered flags; a full FIFO still accepts a pop,
   // an empty one still accepts a push, with no pass-through.
   assign o_wr_en = i_wr & ~o_full  & ~i_clr;
   assign o_rd_en = i_rd & ~o_empty & ~i_clr;
   assign op      = fifo_op_t'({o_wr_en, o_rd_en});

   fifo_ptr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_wptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (i_clr),
      .i_inc (o_wr_en),
      .o_ptr (o_waddr)
   );

   fifo_ptr_wrap #(.AW(AW), .DEPTH(DEPTH)) u_rptr (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (i_clr),
      .i_inc (o_rd_en),
      .o_ptr (o_raddr)
   );

   // Flags are registered from the next count so they line up with o_count.
   always_comb begin
      count_nxt     = o_count;
      overflow_nxt  = o_overflow;
      underflow_nxt = o_underflow;
      if (i_clr) begin
         count_nxt     = '0;
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end else begin
         unique case (op)
            OP_WR:   count_nxt = o_count + ONE_C;
            OP_RD:   count_nxt = o_count - ONE_C;
            OP_RDWR: count_nxt = o_count;
            default: count_nxt = o_count;
         endcase
         if (i_wr && o_full)  overflow_nxt  = 1'b1;
         if (i_rd && o_empty) underflow_nxt = 1'b1;
      end
      full_nxt   = (count_nxt == DEPTH_C);
      empty_nxt  = (count_nxt == '0);
      afull_nxt  = (count_nxt >= AF_C);
      aempty_nxt = (count_nxt <= AE_C);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_count     <= '0;
         o_full      <= 1'b0;
         o_empty     <= 1'b1;
         o_afull     <= 1'b0;
         o_aempty    <= 1'b1;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_count     <= count_nxt;
         o_full      <= full_nxt;
         o_empty     <= empty_nxt;
         o_afull     <= afull_nxt;
         o_aempty    <= aempty_nxt;
         o_overflow  <= overflow_nxt;
         o_underflow <= underflow_nxt;
      end
   end

   // Occupancy implied by the pointers, modulo DEPTH.
   logic [AW:0] ptr_diff;
   always_comb begin
      ptr_diff = '0;
      if (o_waddr >= o_raddr) begin
         ptr_diff = {1'b0, o_waddr} - {1'b0, o_raddr};
      end else begin
         ptr_diff = {1'b0, o_waddr} + DEPTH_C - {1'b0, o_raddr};
      end
   end

   always @(posedge i_clk) begin
      if (!i_rst) begin
         if (o_full) begin
            assert (o_waddr == o_raddr);
         end else begin
            assert (o_count == ptr_diff);
         end
         assert (!(o_full && o_empty));
         assert (!(o_wr_en && o_full));
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_thresh.sv
module tb_fifo_ctrl_thresh;

   localparam int AW       = 4;
   localparam int DEPTH    = 10;
   localparam int AF_LEVEL = 8;
   localparam int AE_LEVEL = 2;

   logic          i_clk;
   logic          i_rst;
   logic          i_wr;
   logic          i_rd;
   logic          i_clr;
   logic          o_wr_en;
   logic          o_rd_en;
   logic [AW-1:0] o_waddr;
   logic [AW-1:0] o_raddr;
   logic [AW:0]   o_count;
   logic          o_full;
   logic          o_empty;
   logic          o_afull;
   logic          o_aempty;
   logic          o_overflow;
   logic          o_underflow;

   int checks   = 0;
   int failures = 0;

   logic [AW:0] exp_q[$];

   fifo_ctrl_thresh #(
      .AW(AW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
   ) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr        (i_wr),
      .i_rd        (i_rd),
      .i_clr       (i_clr),
      .o_wr_en     (o_wr_en),
      .o_rd_en     (o_rd_en),
      .o_waddr     (o_waddr),
      .o_raddr     (o_raddr),
      .o_count     (o_count),
      .o_full      (o_full),
      .o_empty     (o_empty),
      .o_afull     (o_afull),
      .o_aempty    (o_aempty),
      .o_overflow  (o_overflow),
      .o_underflow (o_underflow)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks: inputs change on the falling edge, away from the active edge
   task automatic set_in(input logic w, input logic r, input logic c);
      @(negedge i_clk);
      i_wr  = w;
      i_rd  = r;
      i_clr = c;
      #1;
   endtask

   task automatic clk_step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic op(input logic w, input logic r, input logic c);
      set_in(w, r, c);
      clk_step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input int wa, input int ra,
                            input logic ovf, input logic unf);
      chk({tag, ".count"},  32'(o_count), 32'(cnt));
      chk({tag, ".waddr"},  32'(o_waddr), 32'(wa));
      chk({tag, ".raddr"},  32'(o_raddr), 32'(ra));
      chk({tag, ".full"},   32'(o_full),   32'(cnt == DEPTH));
      chk({tag, ".empty"},  32'(o_empty),  32'(cnt == 0));
      chk({tag, ".afull"},  32'(o_afull),  32'(cnt >= AF_LEVEL));
      chk({tag, ".aempty"}, 32'(o_aempty), 32'(cnt <= AE_LEVEL));
      chk({tag, ".ovf"},    32'(o_overflow),  32'(ovf));
      chk({tag, ".unf"},    32'(o_underflow), 32'(unf));
   endtask

   initial begin
      i_rst = 1'b1;
      i_wr  = 1'b0;
      i_rd  = 1'b0;
      i_clr = 1'b0;
      #12;
      chk_state("reset", 0, 0, 0, 1'b0, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // fill 0 -> 10; thresholds: aempty drops at 3, afull rises at 8
      for (int k = 1; k <= DEPTH; k++) exp_q.push_back((AW+1)'(k));
      for (int k = 1; k <= DEPTH; k++) begin
         logic [AW:0] e;
         op(1'b1, 1'b0, 1'b0);
         e = exp_q.pop_front();
         chk($sformatf("fill%0d.count", k), 32'(o_count), 32'(e));
         chk($sformatf("fill%0d.aempty", k), 32'(o_aempty), 32'(k <= 2));
         chk($sformatf("fill%0d.afull", k), 32'(o_afull), 32'(k >= 8));
      end
      chk_state("full", 10, 0, 0, 1'b0, 1'b0);

      // full with push+pop: pop only, overflow set
      set_in(1'b1, 1'b1, 1'b0);
      chk("full_rw.wr_en", 32'(o_wr_en), 32'(0));
      chk("full_rw.rd_en", 32'(o_rd_en), 32'(1));
      clk_step();
      chk_state("full_rw", 9, 0, 1, 1'b1, 1'b0);

      // down to 7, overflow still held, then flush with a push pending
      op(1'b0, 1'b1, 1'b0);
      op(1'b0, 1'b1, 1'b0);
      chk_state("cnt7", 7, 0, 3, 1'b1, 1'b0);
      set_in(1'b1, 1'b1, 1'b1);
      chk("clr.wr_en", 32'(o_wr_en), 32'(0));
      chk("clr.rd_en", 32'(o_rd_en), 32'(0));
      clk_step();
      chk_state("clr", 0, 0, 0, 1'b0, 1'b0);

      // empty with push+pop: push only, underflow set
      set_in(1'b1, 1'b1, 1'b0);
      chk("empty_rw.wr_en", 32'(o_wr_en), 32'(1));
      chk("empty_rw.rd_en", 32'(o_rd_en), 32'(0));
      clk_step();
      chk_state("empty_rw", 1, 1, 0, 1'b0, 1'b1);

      // bring to 5, then 20 simultaneous push+pop cycles
      for (int k = 0; k < 4; k++) op(1'b1, 1'b0, 1'b0);
      chk_state("cnt5", 5, 5, 0, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         op(1'b1, 1'b1, 1'b0);
         chk($sformatf("rw%0d.count", i), 32'(o_count), 32'(5));
         if (i == 6) begin
            chk("rw6.waddr", 32'(o_waddr), 32'(2));
            chk("rw6.raddr", 32'(o_raddr), 32'(7));
         end
      end
      chk_state("rw20", 5, 5, 0, 1'b0, 1'b1);

      // drain, then pop while empty leaves state unchanged
      for (int k = 0; k < 5; k++) op(1'b0, 1'b1, 1'b0);
      chk_state("drain", 0, 5, 5, 1'b0, 1'b1);
      set_in(1'b0, 1'b1, 1'b0);
      chk("empty_rd.rd_en", 32'(o_rd_en), 32'(0));
      clk_step();
      chk_state("empty_rd", 0, 5, 5, 1'b0, 1'b1);

      // reset asserted mid-burst, away from any clock edge
      for (int k = 0; k < 3; k++) op(1'b1, 1'b0, 1'b0);
      chk_state("burst", 3, 8, 5, 1'b0, 1'b1);
      set_in(1'b1, 1'b0, 1'b0);
      #1;
      i_rst = 1'b1;
      #1;
      chk_state("async_rst", 0, 0, 0, 1'b0, 1'b0);
      clk_step();
      chk_state("rst_hold", 0, 0, 0, 1'b0, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;
      i_wr  = 1'b0;
      op(1'b1, 1'b0, 1'b0);
      chk_state("post_rst", 1, 1, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
